// File: rtl/fault_msg_scheduler.sv
// Fault message scheduler: CDC 4-phase capture into IFM/PBM queues,
// PBM-first dequeue, sticky IFM flags and overflow accounting.

module fault_msg_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               data_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] wrap_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wrap_inc(wr_q);
      if (pop_i)  rd_d = wrap_inc(rd_q);
      unique case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is never reset; head is masked by the consumer when empty.
  always_ff @(posedge clock) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
endmodule

module fault_msg_scheduler #(
  parameter int CODE_W    = 4,
  parameter int IFM_DEPTH = 4,
  parameter int PBM_DEPTH = 2,
  parameter int EU_CODE   = 1,
  parameter int RU_CODE   = 4,
  parameter int CU_CODE   = 5
) (
  input  logic                           clock,
  input  logic                           rst_n,
  input  logic                           req,
  input  logic [CODE_W-1:0]              f_cdc_code,
  output logic                           ack,
  output logic                           deq_valid,
  output logic [CODE_W-1:0]              deq_code,
  output logic                           deq_is_pbm,
  input  logic                           deq_ready,
  input  logic                           flush,
  output logic [2:0]                     ifm_led,
  output logic [$clog2(IFM_DEPTH+1)-1:0] ifm_count,
  output logic [$clog2(PBM_DEPTH+1)-1:0] pbm_count,
  output logic                           overflow,
  output logic [7:0]                     drop_count
);
  typedef enum logic {IDLE, ACKED} hs_state_e;

  hs_state_e   state_q;
  logic        ack_q;
  logic [1:0]  sync_q;
  logic        req_s;
  logic        capture;

  logic        hit_eu, hit_ru, hit_cu;
  logic        is_ifm, is_pbm;

  logic [CODE_W-1:0] ifm_head, pbm_head;
  logic        ifm_full, ifm_empty;
  logic        pbm_full, pbm_empty;
  logic        ifm_push, pbm_push;
  logic        ifm_pop, pbm_pop;
  logic        ifm_acc, pbm_acc;
  logic        drop;

  logic [2:0]  led_q, led_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  drop_q, drop_d;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], req};
  end

  assign req_s = sync_q[1];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (req_s) begin
          state_q <= ACKED;
          ack_q   <= 1'b1;
        end
        ACKED: if (!req_s) begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign capture = (state_q == IDLE) && req_s;

  assign hit_eu = (f_cdc_code == CODE_W'(EU_CODE));
  assign hit_ru = (f_cdc_code == CODE_W'(RU_CODE));
  assign hit_cu = (f_cdc_code == CODE_W'(CU_CODE));
  assign is_ifm = hit_eu | hit_ru | hit_cu;
  assign is_pbm = !is_ifm && (f_cdc_code != '0);

  // PBM head always wins; IFM pops only when no PBM is waiting.
  assign pbm_pop = deq_ready && !pbm_empty;
  assign ifm_pop = deq_ready && pbm_empty && !ifm_empty;

  assign ifm_push = capture && is_ifm;
  assign pbm_push = capture && is_pbm;
  assign ifm_acc  = ifm_push && (!ifm_full || ifm_pop);
  assign pbm_acc  = pbm_push && (!pbm_full || pbm_pop);
  assign drop     = !flush &&
                    ((ifm_push && !ifm_acc) ||
                     (pbm_push && !pbm_acc));

  fault_msg_fifo #(
    .W     (CODE_W),
    .DEPTH (IFM_DEPTH)
  ) u_ifm (
    .clock   (clock),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (ifm_acc),
    .pop_i   (ifm_pop),
    .data_i  (f_cdc_code),
    .head_o  (ifm_head),
    .count_o (ifm_count),
    .full_o  (ifm_full),
    .empty_o (ifm_empty)
  );

  fault_msg_fifo #(
    .W     (CODE_W),
    .DEPTH (PBM_DEPTH)
  ) u_pbm (
    .clock   (clock),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (pbm_acc),
    .pop_i   (pbm_pop),
    .data_i  (f_cdc_code),
    .head_o  (pbm_head),
    .count_o (pbm_count),
    .full_o  (pbm_full),
    .empty_o (pbm_empty)
  );

  always_comb begin
    led_d  = led_q;
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (ifm_acc && !flush) begin
      led_d = led_q | {hit_cu, hit_ru, hit_eu};
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      led_q  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      led_q  <= led_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  assign ack        = ack_q;
  assign deq_valid  = !ifm_empty || !pbm_empty;
  assign deq_is_pbm = !pbm_empty;
  assign deq_code   = !pbm_empty ? pbm_head :
                      (!ifm_empty ? ifm_head : '0);
  assign ifm_led    = led_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_fault_msg_scheduler.sv
// Bench for fault_msg_scheduler: queue-level reference model
// checked every cycle, plus directed literal expectations.

module tb_fault_msg_scheduler;
  localparam int CW = 4;
  localparam int ID = 4;
  localparam int PD = 2;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          deq_ready = 1'b0;
  logic          flush = 1'b0;
  logic [CW-1:0] f_cdc_code = '0;
  logic          ack;
  logic          deq_valid;
  logic          deq_is_pbm;
  logic [CW-1:0] deq_code;
  logic [2:0]    ifm_led;
  logic [2:0]    ifm_count;
  logic [1:0]    pbm_count;
  logic          overflow;
  logic [7:0]    drop_count;

  always #5 clock = ~clock;

  fault_msg_scheduler #(
    .CODE_W    (CW),
    .IFM_DEPTH (ID),
    .PBM_DEPTH (PD),
    .EU_CODE   (1),
    .RU_CODE   (4),
    .CU_CODE   (5)
  ) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .req        (req),
    .f_cdc_code (f_cdc_code),
    .ack        (ack),
    .deq_valid  (deq_valid),
    .deq_code   (deq_code),
    .deq_is_pbm (deq_is_pbm),
    .deq_ready  (deq_ready),
    .flush      (flush),
    .ifm_led    (ifm_led),
    .ifm_count  (ifm_count),
    .pbm_count  (pbm_count),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endfunction

  // Reference model: two queues of codes and sticky status
  int       m_ifm[$];
  int       m_pbm[$];
  bit       m_p1 = 0;
  bit       m_p2 = 0;
  bit       m_ack = 0;
  bit       m_ovf = 0;
  bit [2:0] m_led = 0;
  int       m_drop = 0;

  always @(posedge clock or negedge rst_n) begin
    bit rs;
    bit cap;
    bit isi;
    int c;
    if (!rst_n) begin
      m_ifm.delete();
      m_pbm.delete();
      m_p1 = 0;
      m_p2 = 0;
      m_ack = 0;
      m_ovf = 0;
      m_led = 0;
      m_drop = 0;
    end else begin
      rs = m_p2;
      m_p2 = m_p1;
      m_p1 = req;
      cap = !m_ack && rs;
      if (cap) m_ack = 1;
      else if (m_ack && !rs) m_ack = 0;
      if (flush) begin
        m_ifm.delete();
        m_pbm.delete();
      end else begin
        if (deq_ready) begin
          if (m_pbm.size() > 0) void'(m_pbm.pop_front());
          else if (m_ifm.size() > 0) void'(m_ifm.pop_front());
        end
        c = int'(f_cdc_code);
        if (cap && c != 0) begin
          isi = (c == 1 || c == 4 || c == 5);
          if (isi && m_ifm.size() < ID) begin
            m_ifm.push_back(c);
            m_led |= (c == 1) ? 3'b001 :
                     (c == 4) ? 3'b010 : 3'b100;
          end else if (!isi && m_pbm.size() < PD) begin
            m_pbm.push_back(c);
          end else begin
            m_ovf = 1;
            if (m_drop < 255) m_drop++;
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    int ec;
    bit ev;
    bit ep;
    ev = (m_ifm.size() + m_pbm.size()) != 0;
    ep = m_pbm.size() != 0;
    chk("ack", ack, m_ack);
    chk("deq_valid", deq_valid, ev);
    if (ev) begin
      ec = ep ? m_pbm[0] : m_ifm[0];
      chk("deq_code", deq_code, ec);
      chk("deq_is_pbm", deq_is_pbm, ep);
    end
    chk("ifm_count", ifm_count, m_ifm.size());
    chk("pbm_count", pbm_count, m_pbm.size());
    chk("ifm_led", ifm_led, m_led);
    chk("overflow", overflow, m_ovf);
    chk("drop_count", drop_count, m_drop);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic wait_ack(input bit lvl);
    int k;
    k = 0;
    while (ack !== lvl && k < 20) begin
      tick(1);
      k++;
    end
    if (ack !== lvl) chk("ack_timeout", ack, lvl);
  endtask

  task automatic send(input logic [CW-1:0] c);
    f_cdc_code = c;
    req = 1'b1;
    wait_ack(1'b1);
    req = 1'b0;
    wait_ack(1'b0);
  endtask

  initial begin
    int exp4[4];
    int exp3[3];
    exp4 = '{4, 5, 1, 1};
    exp3 = '{9, 3, 1};

    tick(3);
    chk("rst_ack", ack, 0);
    chk("rst_valid", deq_valid, 0);
    chk("rst_ifm_cnt", ifm_count, 0);
    chk("rst_led", ifm_led, 0);
    chk("rst_drop", drop_count, 0);
    rst_n = 1'b1;
    tick(1);

    // Single EU message, ack latency of three edges
    f_cdc_code = 4'd1;
    req = 1'b1;
    tick(2);
    chk("ack_early", ack, 0);
    tick(1);
    chk("ack_3cyc", ack, 1);
    chk("eu_cnt", ifm_count, 1);
    chk("eu_led", ifm_led, 3'b001);
    chk("eu_code", deq_code, 1);
    chk("eu_pbm", deq_is_pbm, 0);
    req = 1'b0;
    wait_ack(1'b0);

    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("flush_cnt", ifm_count, 0);
    chk("flush_led", ifm_led, 3'b001);

    // PBM outranks earlier IFM
    send(4'd4);
    send(4'd2);
    chk("prio_code", deq_code, 2);
    chk("prio_pbm", deq_is_pbm, 1);
    chk("prio_led", ifm_led, 3'b011);
    deq_ready = 1'b1;
    tick(1);
    chk("prio_code2", deq_code, 4);
    chk("prio_pbm2", deq_is_pbm, 0);
    tick(1);
    chk("prio_empty", deq_valid, 0);
    deq_ready = 1'b0;

    // IFM overflow
    send(4'd1);
    send(4'd4);
    send(4'd5);
    send(4'd1);
    send(4'd4);
    chk("ovf_cnt", ifm_count, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_count, 1);
    chk("ovf_led", ifm_led, 3'b111);

    // Push into full queue on the same edge as a pop
    f_cdc_code = 4'd1;
    req = 1'b1;
    tick(2);
    deq_ready = 1'b1;
    tick(1);
    deq_ready = 1'b0;
    chk("fp_ack", ack, 1);
    chk("fp_cnt", ifm_count, 4);
    chk("fp_drop", drop_count, 1);
    chk("fp_head", deq_code, 4);
    req = 1'b0;
    wait_ack(1'b0);
    deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fp_order", deq_code, exp4[i]);
      tick(1);
    end
    chk("fp_drained", deq_valid, 0);
    deq_ready = 1'b0;

    // Zero code is acknowledged and discarded
    send(4'd0);
    chk("zero_valid", deq_valid, 0);
    chk("zero_ifm", ifm_count, 0);
    chk("zero_pbm", pbm_count, 0);

    // PBM pre-emption and PBM overflow
    send(4'd1);
    chk("pre_ifm", deq_is_pbm, 0);
    send(4'd9);
    chk("pre_code", deq_code, 9);
    chk("pre_pbm", deq_is_pbm, 1);
    send(4'd3);
    send(4'd6);
    chk("pbm_full", pbm_count, 2);
    chk("pbm_drop", drop_count, 2);
    deq_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("pbm_order", deq_code, exp3[i]);
      tick(1);
    end
    chk("pbm_drained", deq_valid, 0);
    deq_ready = 1'b0;

    // Reset while acknowledged with req held high
    f_cdc_code = 4'd5;
    req = 1'b1;
    wait_ack(1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_cnt", ifm_count, 0);
    chk("mid_rst_drop", drop_count, 0);
    tick(2);
    rst_n = 1'b1;
    wait_ack(1'b1);
    chk("recap_cnt", ifm_count, 1);
    chk("recap_code", deq_code, 5);
    chk("recap_led", ifm_led, 3'b100);
    req = 1'b0;
    wait_ack(1'b0);

    // drop_count saturation
    send(4'd8);
    send(4'd8);
    for (int i = 0; i < 256; i++) send(4'd8);
    chk("sat_drop", drop_count, 255);
    chk("sat_ovf", overflow, 1);
    chk("sat_pbm", pbm_count, 2);

    tick(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fault_msg_scheduler.md
FAULT_MSG_SCHEDULER -- requirements
Module: fault_msg_scheduler

Interface
REQ-001 SHALL have parameter CODE_W, default 4: message code width.
REQ-002 SHALL have parameter IFM_DEPTH, default 4: IFM queue depth (>=2).
REQ-003 SHALL have parameter PBM_DEPTH, default 2: PBM queue depth (>=2).
REQ-004 SHALL have parameters EU_CODE=1, RU_CODE=4, CU_CODE=5: IFM codes for units 0/1/2.
REQ-005 SHALL have port clock  in  1: single clock; every flop on posedge.
REQ-006 SHALL have port rst_n  in  1: reset, asynchronous, active-low.
REQ-007 SHALL have port req  in  1: 4-phase request from the other clock domain.
REQ-008 SHALL have port f_cdc_code  in  CODE_W: message code, stable while req high.
REQ-009 SHALL have port ack  out  1: 4-phase acknowledge.
REQ-010 SHALL have port deq_valid  out  1: a message is available.
REQ-011 SHALL have port deq_code  out  CODE_W: head message code.
REQ-012 SHALL have port deq_is_pbm  out  1: head comes from the PBM queue.
REQ-013 SHALL have port deq_ready  in  1: consumer takes head when deq_valid high.
REQ-014 SHALL have port flush  in  1: synchronous clear of both queues.
REQ-015 SHALL have port ifm_led  out  3: sticky per-unit "IFM received" flags {cu,ru,eu}.
REQ-016 SHALL have ports ifm_count/pbm_count  out  $clog2(depth+1): current occupancy.
REQ-017 SHALL have port overflow  out  1: sticky, a message was dropped.
REQ-018 SHALL have port drop_count  out  8: dropped messages, saturates at 255.

Function
REQ-019 req SHALL pass a 2-flop synchroniser; req_s denotes its output.
REQ-020 Handshake FSM SHALL have states IDLE and ACKED; IDLE->ACKED when req_s=1 (capture cycle), ACKED->IDLE when req_s=0.
REQ-021 ack SHALL equal 1 exactly while state=ACKED (registered); req rising at edge N gives ack=1 after edge N+3.
REQ-022 On the capture cycle f_cdc_code SHALL be classified: equal to EU/RU/CU_CODE -> IFM; other nonzero -> PBM; zero -> discarded (still acknowledged).
REQ-023 Exactly one message SHALL be captured per req high phase; ack is never withheld, including on drop.
REQ-024 Each queue SHALL be a circular FIFO with wrapping read/write pointers and an occupancy count.
REQ-025 Dequeue priority: PBM head SHALL be presented whenever pbm_count>0, otherwise IFM head; deq_is_pbm flags the source.
REQ-026 deq_valid SHALL be (ifm_count+pbm_count)!=0; deq_code and deq_is_pbm SHALL be combinational from queue heads.
REQ-027 Pop SHALL occur on a cycle with deq_valid & deq_ready, from the presented queue only.
REQ-028 Push into a full queue in the same cycle as a pop from that queue SHALL be accepted (count unchanged).
REQ-029 Push into a full queue without a same-cycle pop SHALL drop the message, set overflow, and increment drop_count (saturating).
REQ-030 Accepted IFM SHALL set the matching ifm_led bit; ifm_led clears only on reset.
REQ-031 flush SHALL zero both counts and pointers at that edge, overriding a same-cycle push or pop; handshake FSM, ifm_led, overflow, drop_count unaffected.
REQ-032 Dequeue order within a queue SHALL be strict FIFO; a PBM arriving while an IFM is presented pre-empts it on the next cycle.

Reset
REQ-033 rst_n=0 SHALL asynchronously force: FSM=IDLE, synchroniser=0, ack=0, counts/pointers=0, deq_valid=0, ifm_led=0, overflow=0, drop_count=0.
REQ-034 Reset mid-handshake SHALL leave ack=0 after release; a still-high req is then captured as a new message.
REQ-035 Queue storage contents need no reset; outputs SHALL not depend on them while empty.

Verification
REQ-036 Send code 1, deq_ready=0 -> ack high 3 cycles after req, ifm_count=1, ifm_led=3'b001, deq_code=1, deq_is_pbm=0.
REQ-037 Send 4 then 2, then deq_ready=1 -> dequeue order 2 (pbm=1) then 4 (pbm=0).
REQ-038 Send 5 IFMs with deq_ready=0 (IFM_DEPTH=4) -> ifm_count=4, overflow=1, drop_count=1, fifth ack still completes.
REQ-039 Full IFM queue, push code 1 with deq_ready=1 same cycle -> ifm_count stays 4, no drop, order preserved.
REQ-040 Send code 0 -> ack completes, counts unchanged, deq_valid=0.
REQ-041 Assert rst_n=0 while ack=1 with req held high -> ack=0 immediately; after release message recaptured, count=1.
